// File: rtl/l2_arb_pkg.sv
// ---------------------------------------------------------------------------
// l2_arb_pkg
//   Shared types, constants and helpers for the L2 port arbiter.
//
//   resp_tag_t       : one response-pipeline entry {valid, master index, err}.
//                      The index field has a fixed width of TAG_IDX_W bits, so
//                      the arbiter supports up to 2**TAG_IDX_W masters.
//   ERR_DATA_DEFAULT : read data returned with an error response.
//   addr_in_window   : checks whether a byte address falls inside the L2 window.
// ---------------------------------------------------------------------------
package l2_arb_pkg;

    localparam int unsigned TAG_IDX_W = 4;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADC_AB1E;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
        logic                 err;
    } resp_tag_t;

    // The window is [base, base + 2**(mem_addr_width+2)). The test is done on
    // 64 bits so that the upper bound cannot wrap for any 32-bit base.
    function automatic logic addr_in_window(input logic [63:0] addr,
                                            input logic [63:0] base,
                                            input int unsigned mem_addr_width);
        logic [63:0] offset;
        offset = addr - base;
        return (addr >= base) && ((offset >> (mem_addr_width + 2)) == 64'd0);
    endfunction

endpackage

// File: rtl/l2_port_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter with an optional fixed-priority override
//   for requester 0.
//
//   req_i       : request vector
//   prio0_i     : when set and req_i[0] is high, requester 0 wins outright
//   rr_ptr_i    : round-robin pointer; the search starts at this index
//   gnt_o       : one-hot grant (all zero when nothing requests)
//   gnt_idx_o   : index of the granted requester (0 when no grant)
//   gnt_valid_o : a grant was issued this cycle
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic             prio0_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    logic found;

    // Two passes: first look for a requester at or above the pointer, then
    // wrap and take the lowest requester. Together they give "first
    // requesting index >= pointer, wrapping".
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;

        if (prio0_i && req_i[0]) begin
            gnt_o[0] = 1'b1;
            found    = 1'b1;
        end

        for (int i = 0; i < int'(N); i++) begin
            if (!found && req_i[i] && (i >= int'(rr_ptr_i))) begin
                gnt_o[i]  = 1'b1;
                gnt_idx_o = IDX_W'(i);
                found     = 1'b1;
            end
        end

        for (int i = 0; i < int'(N); i++) begin
            if (!found && req_i[i]) begin
                gnt_o[i]  = 1'b1;
                gnt_idx_o = IDX_W'(i);
                found     = 1'b1;
            end
        end

        gnt_valid_o = found;
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter
//   Shares one single-port L2 SRAM between NUM_MASTERS request/grant masters.
//   Master 0 is the JTAG debug master. Arbitration is round-robin with an
//   optional debug-priority override. Every granted access, including an
//   out-of-window one, gets exactly one response MEM_LATENCY cycles later.
//
//   Handshake: a master raises req_i[m] with a stable payload and holds it
//   until gnt_o[m] is high. The cycle in which gnt_o[m] is high completes the
//   transfer, and a new request may follow in the next cycle. Exactly
//   MEM_LATENCY cycles after a grant, rvalid_o[m] pulses for one cycle with
//   rdata_o[m]/rerr_o[m]. There is no back-pressure on responses.
//
//   Ports
//     clk_i, rst_n            clock, asynchronous active-low reset
//     debug_prio_i            master 0 has fixed highest priority
//     req_i/addr_i/we_i/be_i/wdata_i   per-master request payload
//     gnt_o                   one-hot grant, combinational from req_i
//     rvalid_o/rdata_o/rerr_o per-master response
//     mem_*_o / mem_rdata_i   SRAM macro interface
// ---------------------------------------------------------------------------
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned           NUM_MASTERS    = 2,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           MEM_ADDR_WIDTH = 14,
    parameter logic [ADDR_WIDTH-1:0] L2_BASE        = '0,
    parameter int unsigned           MEM_LATENCY    = 1,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_n,
    input  logic                                        debug_prio_i,
    input  logic [NUM_MASTERS-1:0]                      req_i,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]      addr_i,
    input  logic [NUM_MASTERS-1:0]                      we_i,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]    be_i,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]      wdata_i,
    output logic [NUM_MASTERS-1:0]                      gnt_o,
    output logic [NUM_MASTERS-1:0]                      rvalid_o,
    output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]      rdata_o,
    output logic [NUM_MASTERS-1:0]                      rerr_o,
    output logic                                        mem_req_o,
    output logic                                        mem_we_o,
    output logic [DATA_WIDTH/8-1:0]                     mem_be_o,
    output logic [MEM_ADDR_WIDTH-1:0]                   mem_addr_o,
    output logic [DATA_WIDTH-1:0]                       mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]                       mem_rdata_i
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [NUM_MASTERS-1:0] arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_valid;
    logic                   grant_live;

    rr_arbiter #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i       (req_i),
        .prio0_i     (debug_prio_i),
        .rr_ptr_i    (rr_q),
        .gnt_o       (arb_gnt),
        .gnt_idx_o   (arb_idx),
        .gnt_valid_o (arb_valid)
    );

    // Grants are suppressed while reset is asserted so that nothing reaches
    // the SRAM and no response is queued.
    assign grant_live = arb_valid & rst_n;
    assign gnt_o      = rst_n ? arb_gnt : '0;

    always_comb begin
        rr_d = rr_q;
        if (grant_live) begin
            rr_d = (arb_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : arb_idx + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Winner payload mux (AND-OR on the one-hot grant)
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  win_we;
    logic [BE_W-1:0]       win_be;
    logic [DATA_WIDTH-1:0] win_wdata;

    always_comb begin
        win_addr  = '0;
        win_we    = 1'b0;
        win_be    = '0;
        win_wdata = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (arb_gnt[i]) begin
                win_addr  = addr_i[i];
                win_we    = we_i[i];
                win_be    = be_i[i];
                win_wdata = wdata_i[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                  in_win;
    logic [ADDR_WIDTH-1:0] win_off;
    logic                  unused_off_bits;

    assign in_win  = addr_in_window(64'(win_addr), 64'(L2_BASE), MEM_ADDR_WIDTH);
    assign win_off = win_addr - L2_BASE;

    // Byte-lane bits and bits above the window do not form the word address.
    assign unused_off_bits = ^{win_off[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], win_off[1:0]};

    assign mem_req_o   = grant_live & in_win;
    assign mem_we_o    = grant_live & win_we;
    assign mem_be_o    = grant_live ? win_be : '0;
    assign mem_addr_o  = grant_live ? win_off[MEM_ADDR_WIDTH+1:2] : '0;
    assign mem_wdata_o = grant_live ? win_wdata : '0;

    // ------------------------------------------------------------------
    // Response tracking pipeline: stage 0 is written in the grant cycle, the
    // last stage is the response presented MEM_LATENCY cycles later, when the
    // SRAM read data is valid.
    // ------------------------------------------------------------------
    resp_tag_t pipe_q [MEM_LATENCY];
    resp_tag_t tag_d;
    resp_tag_t head;

    always_comb begin
        tag_d = '0;
        if (grant_live) begin
            tag_d.valid = 1'b1;
            tag_d.idx   = TAG_IDX_W'(arb_idx);
            tag_d.err   = ~in_win;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
            for (int s = 0; s < int'(MEM_LATENCY); s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            rr_q      <= rr_d;
            pipe_q[0] <= tag_d;
            for (int s = 1; s < int'(MEM_LATENCY); s++) begin
                pipe_q[s] <= pipe_q[s-1];
            end
        end
    end

    assign head = pipe_q[MEM_LATENCY-1];

    always_comb begin
        rvalid_o = '0;
        rerr_o   = '0;
        rdata_o  = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (head.valid && (head.idx == TAG_IDX_W'(i))) begin
                rvalid_o[i] = 1'b1;
                rerr_o[i]   = head.err;
                rdata_o[i]  = head.err ? ERR_DATA : mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
module tb_l2_port_arbiter;

    localparam int          NM       = 2;
    localparam int          LAT      = 2;
    localparam logic [31:0] ERR_WORD = 32'hBADC_AB1E;
    localparam logic [31:0] WIN_TOP  = 32'h0001_0000;  // L2_BASE 0, 64 KiB window

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 debug_prio;
    logic [NM-1:0]        req;
    logic [NM-1:0][31:0]  addr;
    logic [NM-1:0]        we;
    logic [NM-1:0][3:0]   be;
    logic [NM-1:0][31:0]  wdata;
    logic [NM-1:0]        gnt_o;
    logic [NM-1:0]        rvalid_o;
    logic [NM-1:0][31:0]  rdata_o;
    logic [NM-1:0]        rerr_o;
    logic                 mem_req_o;
    logic                 mem_we_o;
    logic [3:0]           mem_be_o;
    logic [13:0]          mem_addr_o;
    logic [31:0]          mem_wdata_o;
    logic [31:0]          mem_rdata_i;

    l2_port_arbiter #(
        .NUM_MASTERS (NM),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .debug_prio_i (debug_prio),
        .req_i        (req),
        .addr_i       (addr),
        .we_i         (we),
        .be_i         (be),
        .wdata_i      (wdata),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .rerr_o       (rerr_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    // ---------------- SRAM environment model (fixed latency LAT=2) ----------------
    logic [31:0] sram [16384];
    logic [31:0] rd_d1 = 32'h0;
    logic [31:0] rd_d2 = 32'h0;
    assign mem_rdata_i = rd_d2;

    initial begin
        for (int i = 0; i < 16384; i++) sram[i] = 32'hFFFF_FFFF;
    end

    always @(posedge clk) begin
        logic [31:0] w;
        rd_d1 <= 32'hDEAD_0000;
        if (mem_req_o) begin
            if (mem_we_o) begin
                w = sram[mem_addr_o];
                for (int b = 0; b < 4; b++) if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
                sram[mem_addr_o] <= w;
            end else begin
                rd_d1 <= sram[mem_addr_o];
            end
        end
        rd_d2 <= rd_d1;
    end

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- scoreboard queues: {err, check_data, data[31:0], due_cycle[31:0]} ----------------
    logic [65:0] exp_q0[$];
    logic [65:0] exp_q1[$];

    function automatic int q_size(input int m);
        return (m == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [65:0] q_front(input int m);
        return (m == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    task automatic q_push(input int m, input logic [65:0] e);
        if (m == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    endtask

    task automatic q_pop(input int m, output logic [65:0] e);
        if (m == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [65:0] e;
        for (int m = 0; m < NM; m++) begin
            if (rvalid_o[m] === 1'b1) begin
                if (q_size(m) == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rvalid master=%0d cycle=%0d actual=1 required=0", m, cyc);
                end else begin
                    q_pop(m, e);
                    chk("resp_cycle", 64'(cyc), 64'(e[31:0]));
                    chk("resp_err", 64'(rerr_o[m]), 64'(e[65]));
                    if (e[64]) chk("resp_data", 64'(rdata_o[m]), 64'(e[63:32]));
                end
            end else begin
                chk("idle_resp_zero", {31'h0, rerr_o[m], rdata_o[m]}, 64'h0);
                if (q_size(m) > 0) begin
                    e = q_front(m);
                    if (int'(e[31:0]) <= cyc) begin
                        q_pop(m, e);
                        checks++;
                        failures++;
                        $display("FAIL missing_rvalid master=%0d cycle=%0d actual=0 required=1", m, cyc);
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [int];
    int          rr_m = 0;

    function automatic logic [31:0] ref_word(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'hFFFF_FFFF;
    endfunction

    // pending requests held by each master until granted
    logic        p_val   [NM];
    logic [31:0] p_addr  [NM];
    logic        p_we    [NM];
    logic [3:0]  p_be    [NM];
    logic [31:0] p_wdata [NM];
    logic        p_dbg = 1'b0;

    task automatic set_req(input int m, input logic [31:0] a, input logic w,
                           input logic [3:0] b, input logic [31:0] d);
        p_val[m] = 1'b1; p_addr[m] = a; p_we[m] = w; p_be[m] = b; p_wdata[m] = d;
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step();
        int           win;
        int           woff;
        logic         inw;
        logic [NM-1:0] exp_gnt;
        logic [31:0]  cur;
        logic [65:0]  e;
        @(negedge clk);
        debug_prio = p_dbg;
        for (int m = 0; m < NM; m++) begin
            req[m] = p_val[m]; addr[m] = p_addr[m]; we[m] = p_we[m];
            be[m] = p_be[m]; wdata[m] = p_wdata[m];
        end
        #1;
        win = -1;
        if (p_dbg && p_val[0]) win = 0;
        else begin
            for (int k = 0; k < NM; k++) begin
                int j;
                j = (rr_m + k) % NM;
                if (win < 0 && p_val[j]) win = j;
            end
        end
        exp_gnt = (win < 0) ? '0 : NM'(1 << win);
        chk("gnt", 64'(gnt_o), 64'(exp_gnt));
        if (win < 0) begin
            chk("mem_req_idle", 64'(mem_req_o), 64'h0);
        end else begin
            inw = (p_addr[win] < WIN_TOP);
            chk("mem_req", 64'(mem_req_o), 64'(inw));
            if (inw) begin
                woff = int'(p_addr[win][15:2]);
                chk("mem_addr", 64'(mem_addr_o), 64'(woff));
                chk("mem_we", 64'(mem_we_o), 64'(p_we[win]));
                if (p_we[win]) begin
                    chk("mem_be", 64'(mem_be_o), 64'(p_be[win]));
                    chk("mem_wdata", 64'(mem_wdata_o), 64'(p_wdata[win]));
                    cur = ref_word(woff);
                    for (int b = 0; b < 4; b++) if (p_be[win][b]) cur[8*b +: 8] = p_wdata[win][8*b +: 8];
                    ref_mem[woff] = cur;
                    e = {1'b0, 1'b0, 32'h0, 32'(cyc + LAT)};
                end else begin
                    e = {1'b0, 1'b1, ref_word(woff), 32'(cyc + LAT)};
                end
            end else begin
                e = {1'b1, 1'b1, ERR_WORD, 32'(cyc + LAT)};
            end
            q_push(win, e);
            p_val[win] = 1'b0;
            rr_m = (win + 1) % NM;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) if (p_val[0] || p_val[1]) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra;
        int          sel;
        rst_n = 1'b0; debug_prio = 1'b0;
        req = '0; addr = '0; we = '0; be = '0; wdata = '0;
        for (int m = 0; m < NM; m++) begin
            p_val[m] = 1'b0; p_addr[m] = '0; p_we[m] = 1'b0; p_be[m] = '0; p_wdata[m] = '0;
        end

        // reset state: grants and SRAM request gated even with requests pending
        repeat (2) begin
            @(negedge clk);
            req = 2'b11; addr[0] = 32'h4; addr[1] = 32'h8;
            #1;
            chk("reset_gnt", 64'(gnt_o), 64'h0);
            chk("reset_mem_req", 64'(mem_req_o), 64'h0);
            chk("reset_rvalid", 64'(rvalid_o), 64'h0);
        end
        @(negedge clk);
        req = '0;
        rst_n = 1'b1;

        // 1: write then read by master 0
        set_req(0, 32'h0000_0000, 1'b1, 4'hF, 32'hABBA_ABBA); step();
        set_req(0, 32'h0000_0000, 1'b0, 4'hF, 32'h0);         step();
        idle(3);

        // 2: both masters continuously reading, round-robin alternation
        for (int c = 0; c < 4; c++) begin
            if (!p_val[0]) set_req(0, 32'h10, 1'b0, 4'hF, 32'h0);
            if (!p_val[1]) set_req(1, 32'h20, 1'b0, 4'hF, 32'h0);
            step();
        end
        drain(); idle(3);

        // 3: debug priority keeps master 0 winning while it requests
        p_dbg = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (!p_val[0]) set_req(0, 32'h14, 1'b0, 4'hF, 32'h0);
            if (!p_val[1]) set_req(1, 32'h24, 1'b0, 4'hF, 32'h0);
            step();
        end
        step();           // master 0 stops requesting; master 1 now wins
        p_dbg = 1'b0;
        drain(); idle(3);

        // 4: out-of-window read by master 1
        set_req(1, 32'h0001_0000, 1'b0, 4'hF, 32'h0); step();
        idle(3);

        // 5: byte-enable write over erased word, then read back
        set_req(0, 32'h0000_0100, 1'b1, 4'b0101, 32'h1122_3344); step();
        set_req(1, 32'h0000_0100, 1'b0, 4'hF, 32'h0);            step();
        idle(3);
        chk("be_merge_model", 64'(ref_word(32'h40)), 64'hFF22_FF44);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            p_dbg = ($urandom_range(0, 7) == 0);
            for (int m = 0; m < NM; m++) begin
                if (!p_val[m] && $urandom_range(0, 3) != 0) begin
                    sel = $urandom_range(0, 9);
                    case (sel)
                        0:       ra = 32'h0001_0000 + $urandom_range(0, 3);
                        1:       ra = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                        2:       ra = 32'h0000_FFFC + $urandom_range(0, 3);
                        default: ra = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                    endcase
                    set_req(m, ra, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
                end
            end
            step();
        end
        p_dbg = 1'b0;
        drain(); idle(4);

        // 6: reset one cycle after a read grant drops the in-flight response
        set_req(0, 32'h0000_0040, 1'b0, 4'hF, 32'h0); step();
        @(negedge clk);
        req = '0;
        #2;
        rst_n = 1'b0;
        exp_q0.delete(); exp_q1.delete();
        for (int m = 0; m < NM; m++) p_val[m] = 1'b0;
        rr_m = 0;
        repeat (3) begin
            @(negedge clk);
            req = 2'b11; addr[0] = 32'h4; addr[1] = 32'h8; we = '0;
            #1;
            chk("rst_gnt_gated", 64'(gnt_o), 64'h0);
            chk("rst_mem_req_gated", 64'(mem_req_o), 64'h0);
            chk("rst_rvalid", 64'(rvalid_o), 64'h0);
        end
        @(negedge clk);
        req = '0;
        rst_n = 1'b1;
        set_req(0, 32'h0000_0008, 1'b0, 4'hF, 32'h0);
        set_req(1, 32'h0000_000C, 1'b0, 4'hF, 32'h0);
        step();           // model pointer is 0: master 0 must win
        drain(); idle(5);

        chk("leftover_q0", 64'(exp_q0.size()), 64'h0);
        chk("leftover_q1", 64'(exp_q1.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
